accum_bcd_display: RTL
======================

Name: accum_bcd_display

Overview:
- Switch-driven accumulator for the board-level lab designs. Each debounced key press adds two operands read from SW into a saturating accumulator.
- The result is converted to BCD by a sequential shift-add-3 (double-dabble) engine and driven onto NDIG active-low seven-segment digits, with status on LEDR.
- It succeeds the combinational switch-to-HEX adder display. Operand width, accumulator width and digit count are parametrised, and it adds clocked, debounced, stateful operation.

Parameters:
- W, 5, operand width; SW carries two W-bit operands.
- ACC_W, 10, accumulator width; saturates at 2^ACC_W-1.
- NDIG, 4, number of HEX digits; the design requires 10^NDIG > 2^ACC_W-1, otherwise elaboration fails.
- DB_CYCLES, 500000, clock cycles a key must be stable to be accepted (10 ms at 50 MHz).

Ports:
- MAX10_CLK1_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- SW  in  2*W  operands: A = SW[2W-1:W], B = SW[W-1:0].
- KEY_ADD_N  in  1  active-low push-button: accumulate A+B.
- KEY_CLR_N  in  1  active-low push-button: clear accumulator.
- LEDR  out  ACC_W+2  [ACC_W-1:0] accumulator, [ACC_W] sticky overflow, [ACC_W+1] busy.
- HEX  out  8*NDIG  digit i on HEX[8i+7:8i]; active-low segments, bit 7 = DP (always 1/off).

Behaviour:
- Reset state (asynchronous, immediate): accumulator 0, overflow 0, busy 0, FSM IDLE, every HEX digit 8'hC0 ("0").
- Each key passes a 2-flop synchroniser, then a debouncer. The debounced level changes only after DB_CYCLES consecutive cycles of a stable synchronised level.
- A debounced high-to-low transition produces a one-cycle pulse (add_p, clr_p). The key must be released and debounced high before it can produce another pulse.
- Segment codes, active low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
- FSM state IDLE:
  - clr_p: accumulator 0, overflow 0, go to CONV.
  - add_p (without clr_p): sum = acc + A + B computed at ACC_W+1 bits. If sum > 2^ACC_W-1, accumulator becomes 2^ACC_W-1 and overflow is set to 1; otherwise accumulator becomes sum. Go to CONV.
  - clr_p and add_p in the same cycle: clear wins and the add is discarded.
- FSM state CONV:
  - Loads the new accumulator value into the shift register on entry.
  - Runs exactly ACC_W cycles of shift-add-3 over NDIG BCD nibbles.
  - busy = 1 throughout CONV.
  - On the last cycle, all HEX digits are registered together, then the FSM returns to IDLE.
- Latency: a pulse in cycle t produces LEDR accumulator/overflow at t+1, busy high from t+1 to t+ACC_W, and the new HEX at t+ACC_W+1.
- Pulses arriving while busy are dropped, not queued.
- HEX never shows intermediate conversion values; it holds the previous result until the update.
- Overflow is sticky: it is cleared only by clr_p or reset. Further adds while saturated leave the accumulator at its maximum.
- SW is sampled only in the add_p cycle; SW changes at other times have no effect.
- Reset asserted mid-CONV aborts the conversion and forces the reset state.

Optional Feature:
- Macro: ACCUM_BLANK_LEADING_EN.
- Defined: leading-zero digits above the most significant non-zero digit display 8'hFF (blank). Digit 0 always shows a value, so 0 displays as a single "0". The reset state shows HEX digit 0 = C0 and all other digits = FF.
- Undefined: all NDIG digits are always driven, with leading zeros shown as C0.

Test Plan:
- Bench setup: DB_CYCLES=4, all other parameters at defaults, blanking macro undefined unless stated.
- Reset: pulse RESET_N low -> LEDR=0 and HEX=C0C0C0C0 during and after reset.
- Single add: SW={5'd17,5'd9}, KEY_ADD_N low for 10 cycles -> LEDR[9:0]=26; busy high for exactly 10 cycles; HEX digit0=82, digit1=A4, digits 2 and 3=C0.
- Saturation: SW={5'd31,5'd31}, 17 debounced presses -> after press 17 the accumulator is 1023, overflow=1 and HEX shows 1023 (B0,A4,C0,F9 from digit0 up). An 18th press leaves everything unchanged.
- Glitch rejection: KEY_ADD_N low for 3 cycles, then high -> no pulse; LEDR and HEX unchanged.
- Busy drop and clear priority:
  - A clr press arriving while busy -> ignored.
  - Both keys debounced in the same cycle -> accumulator 0, overflow 0, HEX C0C0C0C0 after 11 cycles.
- Reset mid-CONV and blanking: RESET_N low at the 5th busy cycle -> immediate reset state. With ACCUM_BLANK_LEADING_EN defined, accumulating 26 gives HEX FF,FF,A4,82 (digit3 down to digit0).

Source files
------------

// File: rtl/accum_bcd_display.sv
// accum_bcd_display
//   Switch-driven saturating accumulator with a sequential binary-to-BCD
//   (shift-add-3) converter driving NDIG active-low seven-segment digits.
//
//   Each debounced press of KEY_ADD_N adds A = SW[2W-1:W] and B = SW[W-1:0]
//   to the accumulator, saturating at 2^ACC_W-1 with a sticky overflow flag.
//   KEY_CLR_N clears the accumulator and the overflow flag. After either
//   operation the FSM spends exactly ACC_W cycles converting the new value
//   to BCD. All HEX digits are updated together at the end of the conversion.
//
// Ports
//   MAX10_CLK1_50  in   system clock
//   RESET_N        in   asynchronous active-low reset
//   SW[2W-1:0]     in   operands, A = SW[2W-1:W], B = SW[W-1:0]
//   KEY_ADD_N      in   active-low push-button: accumulate A+B
//   KEY_CLR_N      in   active-low push-button: clear accumulator
//   LEDR[ACC_W+1:0] out [ACC_W-1:0] accumulator, [ACC_W] sticky overflow,
//                       [ACC_W+1] busy (conversion in progress)
//   HEX[8*NDIG-1:0] out digit i on HEX[8i+7:8i], active-low, bit 7 = DP (off)
//
// Build option
//   ACCUM_BLANK_LEADING_EN : when defined, zero digits above the most
//   significant non-zero digit are blanked (8'hFF); digit 0 always shows a
//   value. When undefined, every digit is driven and leading zeros show "0".

module accum_bcd_display #(
    parameter int W         = 5,
    parameter int ACC_W     = 10,
    parameter int NDIG      = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic                MAX10_CLK1_50,
    input  logic                RESET_N,
    input  logic [2*W-1:0]      SW,
    input  logic                KEY_ADD_N,
    input  logic                KEY_CLR_N,
    output logic [ACC_W+1:0]    LEDR,
    output logic [8*NDIG-1:0]   HEX
);

    // ------------------------------------------------------------------
    // Elaboration-time checks and derived constants
    // ------------------------------------------------------------------
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned DEC_RANGE = pow10(NDIG);
    localparam longint unsigned ACC_MAX   = (64'd1 << ACC_W) - 64'd1;

    generate
        if (DEC_RANGE <= ACC_MAX) begin : g_ndig_too_small
            $error("accum_bcd_display: 10^NDIG must exceed 2^ACC_W-1");
        end
    endgenerate

    localparam int SUM_W  = ACC_W + 1;
    localparam int SR_W   = 4 * NDIG + ACC_W;
    localparam int CNT_W  = $clog2(DB_CYCLES + 1);
    localparam int STEP_W = $clog2(ACC_W + 1);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ACC_W - 1);

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Display pattern for an accumulator value of zero
    function automatic logic [8*NDIG-1:0] hex_reset_value();
        logic [8*NDIG-1:0] h;
        h = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
`ifdef ACCUM_BLANK_LEADING_EN
            h[8*i +: 8] = (i == 0) ? 8'hC0 : 8'hFF;
`else
            h[8*i +: 8] = 8'hC0;
`endif
        end
        return h;
    endfunction

    localparam logic [8*NDIG-1:0] HEX_RST = hex_reset_value();

    // ------------------------------------------------------------------
    // Key synchronisers and debouncers; index 0 = add, index 1 = clear
    // ------------------------------------------------------------------
    logic [1:0]       w_key_n;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_db;
    logic [1:0]       r_pulse;
    logic [CNT_W-1:0] r_cnt [2];

    assign w_key_n = {KEY_CLR_N, KEY_ADD_N};

    // The counter runs only while the synchronised level differs from the
    // debounced level; any return to the debounced level restarts it. A
    // pulse is emitted only on the debounced high-to-low change, so a key
    // must be released and debounced high before it can fire again.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            r_pulse <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_key_n;
            r_sync2 <= r_sync1;
            r_pulse <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                if (r_sync2[k] != r_db[k]) begin
                    if (r_cnt[k] == DB_LAST) begin
                        r_db[k]    <= r_sync2[k];
                        r_cnt[k]   <= '0;
                        r_pulse[k] <= ~r_sync2[k];
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    logic w_add_p;
    logic w_clr_p;

    assign w_add_p = r_pulse[0];
    assign w_clr_p = r_pulse[1];

    // ------------------------------------------------------------------
    // Accumulator next value
    // ------------------------------------------------------------------
    logic [W-1:0]     w_op_a;
    logic [W-1:0]     w_op_b;
    logic [SUM_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    assign w_op_a = SW[2*W-1:W];
    assign w_op_b = SW[W-1:0];

    // Clear takes priority over a simultaneous add
    always_comb begin
        w_sum     = SUM_W'(r_acc) + SUM_W'(w_op_a) + SUM_W'(w_op_b);
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (w_clr_p) begin
            w_acc_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (w_add_p) begin
            if (w_sum[ACC_W]) begin
                w_acc_nxt = '1;
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic              w_step_last;
    logic              w_busy;
    logic              w_load;
    logic              w_last;

    assign w_step_last = (r_step == STEP_LAST);

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_add_p || w_clr_p) w_state_nxt = S_CONV;
            S_CONV: if (w_step_last)        w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Pulses seen in CONV are simply not acted on, which drops them
    always_comb begin
        w_busy = (r_state == S_CONV);
        w_load = (r_state == S_IDLE) && (w_add_p || w_clr_p);
        w_last = (r_state == S_CONV) && w_step_last;
    end

    // ------------------------------------------------------------------
    // Double-dabble step: {BCD nibbles, binary} shifted left once per cycle
    // after adding 3 to every nibble that is 5 or more
    // ------------------------------------------------------------------
    logic [SR_W-1:0]   r_shreg;
    logic [SR_W-1:0]   w_adj;
    logic [SR_W-1:0]   w_shreg_step;
    logic [4*NDIG-1:0] w_bcd_final;
    logic [8*NDIG-1:0] w_hex_new;
    logic [8*NDIG-1:0] r_hex;

    always_comb begin
        w_adj = r_shreg;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (r_shreg[ACC_W + 4*i +: 4] >= 4'd5) begin
                w_adj[ACC_W + 4*i +: 4] = r_shreg[ACC_W + 4*i +: 4] + 4'd3;
            end
        end
        w_shreg_step = {w_adj[SR_W-2:0], 1'b0};
        w_bcd_final  = w_shreg_step[SR_W-1 -: 4*NDIG];
    end

`ifdef ACCUM_BLANK_LEADING_EN
    logic w_lead;

    // Walk from the top digit down; blank while every digit so far is zero.
    // Digit 0 is never blanked.
    always_comb begin
        w_lead    = 1'b1;
        w_hex_new = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            w_hex_new[8*i +: 8] = seg7(w_bcd_final[4*i +: 4]);
        end
        for (int unsigned k = 0; k + 1 < NDIG; k++) begin
            if (w_lead && (w_bcd_final[4*(NDIG-1-k) +: 4] == 4'd0)) begin
                w_hex_new[8*(NDIG-1-k) +: 8] = 8'hFF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_hex_new = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            w_hex_new[8*i +: 8] = seg7(w_bcd_final[4*i +: 4]);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // The shift register is loaded on the IDLE->CONV edge with the value the
    // accumulator is taking, so CONV cycle 1 already performs step 1. HEX is
    // written only from the result of the final step.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_shreg <= '0;
            r_step  <= '0;
            r_hex   <= HEX_RST;
        end else if (w_load) begin
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_shreg <= SR_W'(w_acc_nxt);
            r_step  <= '0;
        end else if (w_busy) begin
            r_shreg <= w_shreg_step;
            r_step  <= r_step + STEP_W'(1);
            if (w_last) begin
                r_hex <= w_hex_new;
            end
        end
    end

    assign LEDR = {w_busy, r_ovf, r_acc};
    assign HEX  = r_hex;

endmodule
